mips32_div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS32 ALU, executing DIV (signed) and DIVU (unsigned). It produces the quotient in LO and the remainder in HI, the inverse of the multiply path. It sits beside the combinational ALU slices and is driven by the execute stage through a start/busy/done handshake. The core is a restoring, one-bit-per-cycle algorithm on operand magnitudes, followed by a sign-correction cycle.

---
 rtl/mips32_alu_pkg.sv | 34 +++
 rtl/div_step.sv | 24 ++
 rtl/mips32_div_unit.sv | 147 ++++++++++++++
 tb/tb_mips32_div_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips32_alu_pkg.sv
// Shared definitions for the MIPS32 ALU slices: datapath width, divider
// state encoding, decoder funct codes and small arithmetic helpers.
package mips32_alu_pkg;

   localparam int WIDTH = 32;

   // Divider FSM encoding
   typedef logic [1:0] div_state_t;
   localparam logic [1:0] DIV_IDLE = 2'd0;
   localparam logic [1:0] DIV_RUN  = 2'd1;
   localparam logic [1:0] DIV_FIX  = 2'd2;
   localparam logic [1:0] DIV_DONE = 2'd3;

   // SPECIAL-opcode funct fields; the decoder drives is_signed from these
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU = 6'h1B;

   // Number of restoring iterations, one quotient bit each
   localparam logic [4:0] DIV_LAST_ITER = 5'd31;

   // Magnitude of a value that is two's complement only when is_signed.
   // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] div_mag(input logic [WIDTH-1:0] v,
                                                input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

   // Conditional two's complement negate used for sign correction
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left,
// bring in the next dividend bit and subtract the divisor if it fits.
module div_step
   import mips32_alu_pkg::*;
(
   input  logic [WIDTH:0]   i_rem,
   input  logic             i_dvd_bit,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH:0]   o_rem,
   output logic             o_q_bit
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;

   assign w_shift = {i_rem[WIDTH-1:0], i_dvd_bit};
   assign w_trial = w_shift - {1'b0, i_dvs};

   // A set top bit of the incoming remainder means the true shifted value
   // exceeds 33 bits and is certainly larger than any 32-bit divisor.
   assign o_q_bit = i_rem[WIDTH] | ~w_trial[WIDTH];
   assign o_rem   = o_q_bit ? w_trial : w_shift;

endmodule

// File: rtl/mips32_div_unit.sv
// Multi-cycle DIV / DIVU unit. Quotient to LO, remainder to HI.
// Restoring division on operand magnitudes, one bit per cycle, followed
// by a single sign-correction cycle.
//
//   state | meaning
//   IDLE  | waiting for start; zero divisor short-cuts straight to DONE
//   RUN   | 32 shift/compare/subtract iterations
//   FIX   | apply quotient/remainder signs, write LO/HI
//   DONE  | done pulse, results valid; start ignored
module mips32_div_unit
   import mips32_alu_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_is_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi,
   output logic             o_div_by_zero
);

   div_state_t       r_state;
   logic [4:0]       r_count;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH:0]   r_rem;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic             r_dbz;

   logic [WIDTH:0]   w_rem_nxt;
   logic             w_q_bit;
   logic             w_accept;
   logic             w_b_zero;

   assign w_accept = (r_state == DIV_IDLE) && i_start;
   assign w_b_zero = (i_b == '0);

   // The dividend magnitude lives in r_quo and is shifted out MSB-first
   // while quotient bits are shifted in at the LSB.
   div_step u_div_step (
      .i_rem     (r_rem),
      .i_dvd_bit (r_quo[WIDTH-1]),
      .i_dvs     (r_dvs),
      .o_rem     (w_rem_nxt),
      .o_q_bit   (w_q_bit)
   );

   // Sequencing: state, iteration counter and handshake flags
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= DIV_IDLE;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            DIV_IDLE: begin
               if (i_start) begin
                  if (w_b_zero) begin
                     r_state <= DIV_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= DIV_RUN;
                     r_count <= '0;
                     r_busy  <= 1'b1;
                  end
               end
            end
            DIV_RUN: begin
               r_count <= r_count + 5'd1;
               if (r_count == DIV_LAST_ITER) begin
                  r_state <= DIV_FIX;
               end
            end
            DIV_FIX: begin
               r_state <= DIV_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            DIV_DONE: begin
               r_state <= DIV_IDLE;
            end
            default: begin
               r_state <= DIV_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Operand capture and the iterative remainder/quotient datapath
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_dvs   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
      end else if (w_accept && !w_b_zero) begin
         r_dvs   <= div_mag(i_b, i_is_signed);
         r_quo   <= div_mag(i_a, i_is_signed);
         r_rem   <= '0;
         r_q_neg <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         r_r_neg <= i_is_signed & i_a[WIDTH-1];
      end else if (r_state == DIV_RUN) begin
         r_rem <= w_rem_nxt;
         r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
      end
   end

   // Architectural results: written by FIX or the zero-divisor path, held otherwise
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_lo  <= '0;
         r_hi  <= '0;
         r_dbz <= 1'b0;
      end else if (w_accept) begin
         if (w_b_zero) begin
            r_lo  <= '1;
            r_hi  <= i_a;
            r_dbz <= 1'b1;
         end else begin
            r_dbz <= 1'b0;
         end
      end else if (r_state == DIV_FIX) begin
         r_lo <= cond_neg(r_quo, r_q_neg);
         r_hi <= cond_neg(r_rem[WIDTH-1:0], r_r_neg);
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_lo          = r_lo;
   assign o_hi          = r_hi;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_mips32_div_unit.sv
// Self-checking bench for mips32_div_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mips32_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] lo;
   logic [31:0] hi;
   logic        div_by_zero;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mips32_div_unit dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_is_signed   (is_signed),
      .i_a           (a),
      .i_b           (b),
      .o_busy        (busy),
      .o_done        (done),
      .o_lo          (lo),
      .o_hi          (hi),
      .o_div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: 64-bit arithmetic avoids the INT_MIN / -1 overflow trap;
   // SV '/' and '%' truncate toward zero with remainder sign of dividend.
   task automatic model(input logic s, input logic [31:0] op_a, input logic [31:0] op_b,
                        output logic [31:0] e_lo, output logic [31:0] e_hi,
                        output logic e_dbz);
      longint sa, sb, q, r;
      if (op_b == 32'd0) begin
         e_lo  = 32'hFFFF_FFFF;
         e_hi  = op_a;
         e_dbz = 1'b1;
      end else begin
         if (s) begin
            sa = longint'($signed(op_a));
            sb = longint'($signed(op_b));
         end else begin
            sa = {32'd0, op_a};
            sb = {32'd0, op_b};
         end
         q = sa / sb;
         r = sa % sb;
         e_lo  = q[31:0];
         e_hi  = r[31:0];
         e_dbz = 1'b0;
      end
   endtask

   // inj_k >= 0 : pulse an extra start (9/3) that many cycles after E0
   // rst_k >= 0 : assert reset that many cycles after E0 and abandon the op
   // poke_done  : raise start during the done cycle; it must be ignored
   task automatic run_op(input logic s, input logic [31:0] op_a, input logic [31:0] op_b,
                         input int inj_k, input int rst_k, input bit poke_done);
      logic [31:0] e_lo, e_hi;
      logic        e_dbz;
      int          k, nbusy, exp_lat;
      model(s, op_a, op_b, e_lo, e_hi, e_dbz);
      exp_lat = (op_b == 32'd0) ? 0 : 33;
      @(negedge clk);
      start = 1'b1; is_signed = s; a = op_a; b = op_b;
      @(posedge clk); #1;
      start = 1'b0; is_signed = ~s; a = $urandom; b = $urandom;
      k = 0; nbusy = 0;
      while (!done && k < 60) begin
         if (busy) nbusy++;
         if (k == rst_k) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_lo", lo, 32'd0);
            chk("rst_hi", hi, 32'd0);
            chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
            return;
         end
         if (k == inj_k) begin
            start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd3;
         end
         @(posedge clk); #1;
         start = 1'b0;
         k++;
      end
      chk("latency", k, exp_lat);
      chk("busy_cycles", nbusy, exp_lat);
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      chk("done", {31'd0, done}, 32'd1);
      chk("lo", lo, e_lo);
      chk("hi", hi, e_hi);
      chk("dbz", {31'd0, div_by_zero}, {31'd0, e_dbz});
      if (poke_done) begin
         start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("lo_hold", lo, e_lo);
      chk("hi_hold", hi, e_hi);
      if (poke_done) begin
         @(posedge clk); #1;
         chk("done_poke_busy", {31'd0, busy}, 32'd0);
         chk("done_poke_done", {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b0;

      run_op(1'b0, 32'd100, 32'd7, -1, -1, 1'b0);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1, 1'b0);
      run_op(1'b0, 32'h1234_5678, 32'd0, -1, -1, 1'b1);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1, -1, 1'b1);
      run_op(1'b0, 32'd50, 32'd5, 10, -1, 1'b0);
      run_op(1'b0, 32'd1000, 32'd3, -1, 16, 1'b0);
      run_op(1'b0, 32'd9, 32'd3, -1, -1, 1'b0);
      run_op(1'b1, 32'd5, 32'd0, -1, -1, 1'b0);
      run_op(1'b1, 32'd3, 32'd7, -1, -1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = $urandom_range(1, 15);
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
            3: rb = $urandom;
            4: begin ra = $urandom_range(0, 1000); rb = $urandom | 32'h0001_0000; end
            default: rb = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
         endcase
         run_op(rs, ra, rb, -1, -1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
